// File: rtl/ar_channel_router_pkg.sv
// Shared AXI read/write-address definitions: arbiter pointer, master tags, slave regions and
// routing targets used by the AR (and later AW) channel routers.
package ar_channel_router_pkg;

    localparam int unsigned AXI_POINTER_BITS = 2;
    localparam int unsigned TAG_W            = 4;

    typedef enum logic [AXI_POINTER_BITS-1:0] {
        DEFAULT = 2'd0,
        SEL0    = 2'd1,
        SEL1    = 2'd2
    } pointer_e;

    localparam logic [TAG_W-1:0] TAG_M0 = 4'h1;
    localparam logic [TAG_W-1:0] TAG_M1 = 4'h2;

    localparam logic [31:0] S0_REGION_BASE = 32'h0000_0000;
    localparam logic [31:0] S1_REGION_BASE = 32'h0001_0000;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_S0   = 2'd1,
        TGT_S1   = 2'd2,
        TGT_SD   = 2'd3
    } target_e;

endpackage

// File: rtl/ar_channel_router_if.sv
// AR-channel bundle between the two masters/arbiter pointer and the three slave ports.
// The slave modport is the router's view; the master modport is the upstream/downstream side.
interface ar_channel_router_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32
) ();
    import ar_channel_router_pkg::*;

    pointer_e                  sel;

    logic [ID_W-1:0]           ARID_M0;
    logic [ID_W-1:0]           ARID_M1;
    logic [ADDR_W-1:0]         ARADDR_M0;
    logic [ADDR_W-1:0]         ARADDR_M1;
    logic [3:0]                ARLEN_M0;
    logic [3:0]                ARLEN_M1;
    logic [2:0]                ARSIZE_M0;
    logic [2:0]                ARSIZE_M1;
    logic [1:0]                ARBURST_M0;
    logic [1:0]                ARBURST_M1;
    logic                      ARVALID_M0;
    logic                      ARVALID_M1;
    logic                      ARREADY_M0;
    logic                      ARREADY_M1;

    logic [ID_W+TAG_W-1:0]     ARID_S;
    logic [ADDR_W-1:0]         ARADDR_S;
    logic [3:0]                ARLEN_S;
    logic [2:0]                ARSIZE_S;
    logic [1:0]                ARBURST_S;
    logic                      ARVALID_S0;
    logic                      ARVALID_S1;
    logic                      ARVALID_SD;
    logic                      ARREADY_S0;
    logic                      ARREADY_S1;
    logic                      ARREADY_SD;

    modport slave (
        input  sel,
        input  ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
        input  ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
        output ARREADY_M0, ARREADY_M1,
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
        output ARVALID_S0, ARVALID_S1, ARVALID_SD,
        input  ARREADY_S0, ARREADY_S1, ARREADY_SD
    );

    modport master (
        output sel,
        output ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
        output ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
        input  ARREADY_M0, ARREADY_M1,
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
        input  ARVALID_S0, ARVALID_S1, ARVALID_SD,
        output ARREADY_S0, ARREADY_S1, ARREADY_SD
    );

endinterface

// File: rtl/ar_channel_router_addr_decoder.sv
// Combinational address decoder: maps an address onto one of two 64 KiB slave regions,
// falling back to the default (DECERR) slave. Shared with the AW-channel router.
module ar_channel_router_addr_decoder
    import ar_channel_router_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter logic [31:0] S0_BASE = S0_REGION_BASE,
    parameter logic [31:0] S1_BASE = S1_REGION_BASE
) (
    input  logic [ADDR_W-1:0] i_addr,
    output target_e           o_target
);

    localparam logic [ADDR_W-1:0] S0_BASE_W = ADDR_W'(S0_BASE);
    localparam logic [ADDR_W-1:0] S1_BASE_W = ADDR_W'(S1_BASE);

    // Offset bits within a region do not take part in the decode.
    logic w_unused_offset;
    assign w_unused_offset = ^i_addr[15:0];

    always_comb begin
        o_target = TGT_SD;
        if (i_addr[ADDR_W-1:16] == S0_BASE_W[ADDR_W-1:16]) begin
            o_target = TGT_S0;
        end else if (i_addr[ADDR_W-1:16] == S1_BASE_W[ADDR_W-1:16]) begin
            o_target = TGT_S1;
        end
    end

endmodule

// File: rtl/ar_channel_router.sv
// AR-channel router: forwards the arbiter-selected master request through a one-entry
// register slice to S0, S1 or the default slave, widening ARID with a master tag.
module ar_channel_router
    import ar_channel_router_pkg::*;
#(
    parameter int unsigned ID_W    = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter logic [31:0] S0_BASE = S0_REGION_BASE,
    parameter logic [31:0] S1_BASE = S1_REGION_BASE
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    ar_channel_router_if.slave  io_ar
);

    logic                  r_buf_valid;
    target_e               r_target;
    logic [ID_W+TAG_W-1:0] r_id;
    logic [ADDR_W-1:0]     r_addr;
    logic [3:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;

    logic                  w_tgt_ready;
    logic                  w_pop;
    logic                  w_space;
    logic                  w_rdy_m0;
    logic                  w_rdy_m1;
    logic                  w_push;
    logic [ID_W+TAG_W-1:0] w_push_id;
    logic [ADDR_W-1:0]     w_push_addr;
    logic [3:0]            w_push_len;
    logic [2:0]            w_push_size;
    logic [1:0]            w_push_burst;
    target_e               w_push_target;

    // Only the ready of the slave the buffered request is aimed at can drain it.
    always_comb begin
        w_tgt_ready = 1'b0;
        unique case (r_target)
            TGT_S0:   w_tgt_ready = io_ar.ARREADY_S0;
            TGT_S1:   w_tgt_ready = io_ar.ARREADY_S1;
            TGT_SD:   w_tgt_ready = io_ar.ARREADY_SD;
            TGT_NONE: w_tgt_ready = 1'b0;
        endcase
    end

    assign w_pop   = r_buf_valid && w_tgt_ready;
    assign w_space = !r_buf_valid || w_pop;

    // The arbiter advances on ready alone, so ready must imply a real handshake.
    assign w_rdy_m0 = ARESETn && (io_ar.sel == SEL0) && io_ar.ARVALID_M0 && w_space;
    assign w_rdy_m1 = ARESETn && (io_ar.sel == SEL1) && io_ar.ARVALID_M1 && w_space;
    assign w_push   = w_rdy_m0 || w_rdy_m1;

    always_comb begin
        if (w_rdy_m1) begin
            w_push_id    = {TAG_M1, io_ar.ARID_M1};
            w_push_addr  = io_ar.ARADDR_M1;
            w_push_len   = io_ar.ARLEN_M1;
            w_push_size  = io_ar.ARSIZE_M1;
            w_push_burst = io_ar.ARBURST_M1;
        end else begin
            w_push_id    = {TAG_M0, io_ar.ARID_M0};
            w_push_addr  = io_ar.ARADDR_M0;
            w_push_len   = io_ar.ARLEN_M0;
            w_push_size  = io_ar.ARSIZE_M0;
            w_push_burst = io_ar.ARBURST_M0;
        end
    end

    ar_channel_router_addr_decoder #(
        .ADDR_W  (ADDR_W),
        .S0_BASE (S0_BASE),
        .S1_BASE (S1_BASE)
    ) u_addr_decoder (
        .i_addr   (w_push_addr),
        .o_target (w_push_target)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_buf_valid <= 1'b0;
            r_target    <= TGT_NONE;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
        end else if (w_push) begin
            r_buf_valid <= 1'b1;
            r_target    <= w_push_target;
            r_id        <= w_push_id;
            r_addr      <= w_push_addr;
            r_len       <= w_push_len;
            r_size      <= w_push_size;
            r_burst     <= w_push_burst;
        end else if (w_pop) begin
            // Payload is left as-is; only validity and target are cleared.
            r_buf_valid <= 1'b0;
            r_target    <= TGT_NONE;
        end
    end

    assign io_ar.ARREADY_M0 = w_rdy_m0;
    assign io_ar.ARREADY_M1 = w_rdy_m1;

    assign io_ar.ARID_S    = r_id;
    assign io_ar.ARADDR_S  = r_addr;
    assign io_ar.ARLEN_S   = r_len;
    assign io_ar.ARSIZE_S  = r_size;
    assign io_ar.ARBURST_S = r_burst;

    assign io_ar.ARVALID_S0 = r_buf_valid && (r_target == TGT_S0);
    assign io_ar.ARVALID_S1 = r_buf_valid && (r_target == TGT_S1);
    assign io_ar.ARVALID_SD = r_buf_valid && (r_target == TGT_SD);

endmodule
